// File: rtl/block_check_pkg.sv
// Shared types and constants for the begin/end balance-checker scheduler.
package block_check_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StDrain,
        StResp
    } sched_state_e;

    localparam logic [7:0]  AsciiSpace   = 8'h20;
    localparam logic [7:0]  AsciiNewline = 8'h0a;
    localparam logic [39:0] KwBegin      = "begin";
    localparam logic [23:0] KwEnd        = "end";

    localparam int unsigned DefNReq       = 4;
    localparam int unsigned DefIdW        = 2;
    localparam int unsigned DefLenW       = 16;
    localparam int unsigned DefTimeoutCyc = 255;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr_i, wrapping.
module rr_pick
    import block_check_pkg::*;
#(
    parameter int unsigned N_REQ = DefNReq,
    parameter int unsigned ID_W  = DefIdW
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic             any_o,
    output logic [ID_W-1:0]  idx_o
);

    logic [ID_W-1:0] cand;

    always_comb begin
        any_o = |req_i;
        idx_o = '0;
        cand  = '0;
        // Walk offsets downward so the smallest offset from ptr_i wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((32'(ptr_i) + 32'(k)) % N_REQ);
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/block_check_sched.sv
// Round-robin scheduler sharing one begin/end balance checker among N_REQ streams.
// Optional stall watchdog compiled in with BLK_SCHED_TIMEOUT_EN.
module block_check_sched
    import block_check_pkg::*;
#(
    parameter int unsigned N_REQ       = DefNReq,
    parameter int unsigned ID_W        = DefIdW,
    parameter int unsigned LEN_W       = DefLenW,
    parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_char_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic               chk_clear_o,
    output logic               chk_en_o,
    output logic [7:0]         chk_in_o,
    input  logic               chk_result_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [ID_W-1:0]    rsp_id_o,
    output logic               rsp_ok_o,
    output logic [LEN_W-1:0]   rsp_len_o,
    output logic               rsp_timeout_o
);

    sched_state_e     state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  gnt_q, gnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic             rsp_ok_q, rsp_ok_d;
    logic [LEN_W-1:0] rsp_len_q, rsp_len_d;

    logic             pick_any;
    logic [ID_W-1:0]  pick_idx;

`ifdef BLK_SCHED_TIMEOUT_EN
    localparam int unsigned StallW = $clog2(TIMEOUT_CYC + 1);
    logic [StallW-1:0] stall_q, stall_d;
    logic              rsp_to_q, rsp_to_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        len_d       = len_q;
        rsp_id_d    = rsp_id_q;
        rsp_ok_d    = rsp_ok_q;
        rsp_len_d   = rsp_len_q;
`ifdef BLK_SCHED_TIMEOUT_EN
        stall_d     = stall_q;
        rsp_to_d    = rsp_to_q;
`endif
        req_ready_o = '0;
        chk_clear_o = 1'b0;
        chk_en_o    = 1'b0;
        chk_in_o    = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    gnt_d   = pick_idx;
                    ptr_d   = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_d = StClear;
                end
            end
            StClear: begin
                chk_clear_o = 1'b1;
                len_d       = '0;
`ifdef BLK_SCHED_TIMEOUT_EN
                stall_d     = '0;
`endif
                state_d     = StStream;
            end
            StStream: begin
                req_ready_o[gnt_q] = 1'b1;
                if (req_valid_i[gnt_q]) begin
                    chk_en_o = 1'b1;
                    chk_in_o = req_char_i[8*gnt_q +: 8];
                    // Saturate so a runaway message never wraps the reported length.
                    len_d    = (&len_q) ? len_q : len_q + 1'b1;
`ifdef BLK_SCHED_TIMEOUT_EN
                    stall_d  = '0;
`endif
                    if (req_last_i[gnt_q]) begin
                        state_d = StDrain;
                    end
                end
`ifdef BLK_SCHED_TIMEOUT_EN
                else if (stall_q == StallW'(TIMEOUT_CYC - 1)) begin
                    rsp_ok_d  = 1'b0;
                    rsp_to_d  = 1'b1;
                    rsp_len_d = len_q;
                    rsp_id_d  = gnt_q;
                    state_d   = StResp;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
`endif
            end
            StDrain: begin
                rsp_ok_d  = chk_result_i;
                rsp_len_d = len_q;
                rsp_id_d  = gnt_q;
`ifdef BLK_SCHED_TIMEOUT_EN
                rsp_to_d  = 1'b0;
`endif
                state_d   = StResp;
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            gnt_q     <= '0;
            len_q     <= '0;
            rsp_id_q  <= '0;
            rsp_ok_q  <= 1'b0;
            rsp_len_q <= '0;
`ifdef BLK_SCHED_TIMEOUT_EN
            stall_q   <= '0;
            rsp_to_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            len_q     <= len_d;
            rsp_id_q  <= rsp_id_d;
            rsp_ok_q  <= rsp_ok_d;
            rsp_len_q <= rsp_len_d;
`ifdef BLK_SCHED_TIMEOUT_EN
            stall_q   <= stall_d;
            rsp_to_q  <= rsp_to_d;
`endif
        end
    end

    assign rsp_valid_o = (state_q == StResp);
    assign rsp_id_o    = rsp_id_q;
    assign rsp_ok_o    = rsp_ok_q;
    assign rsp_len_o   = rsp_len_q;
`ifdef BLK_SCHED_TIMEOUT_EN
    assign rsp_timeout_o = rsp_to_q;
`else
    assign rsp_timeout_o = 1'b0;
`endif

endmodule
